// File: rtl/axi_pkg.sv
// AXI4 encodings, field types and the error-priority helper shared by the memory responder.
package axi_pkg;

  typedef logic [7:0] len_t;
  typedef logic [2:0] size_t;
  typedef logic [1:0] burst_t;
  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;
  localparam burst_t BURST_RSVD  = 2'b11;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    len_t        len;
    size_t       size;
    burst_t      burst;
  } req_t;

  // A decode error outranks a slave error when both are present in one burst.
  function automatic resp_t resp_merge(input logic dec_err, input logic slv_err);
    resp_t r;
    r = RESP_OKAY;
    if (dec_err) begin
      r = RESP_DECERR;
    end else if (slv_err) begin
      r = RESP_SLVERR;
    end
    return r;
  endfunction

  function automatic logic size_legal(input size_t size);
    return size <= 3'd3;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts, plus whether a WRAP length is legal.
// Latency: purely combinational. Backpressure: none, the caller decides when to advance.
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [63:0] addr,
  input  len_t        len,
  input  size_t       size,
  input  burst_t      burst,
  output logic [63:0] next_addr,
  output logic        wrap_ok
);

  logic [63:0] step;
  logic [63:0] win_mask;
  logic [63:0] incr_addr;

  always_comb begin
    step      = 64'd1 << size;
    win_mask  = ((64'(len) + 64'd1) << size) - 64'd1;
    incr_addr = addr + step;
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = incr_addr;
      // Keep the bits above the window, let the low bits roll over inside it.
      BURST_WRAP: next_addr = (addr & ~win_mask) | (incr_addr & win_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory serving one read or write burst at a time from a 64-bit word array.
// Latency: AW/AR granted in IDLE, W/R beats from the next cycle, B one cycle after the last W.
// Backpressure: W always ready in WRITE; B and R outputs are held stable until bready/rready.
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [3:0]  io_axi_mem_awid,
  input  logic [63:0] io_axi_mem_awaddr,
  input  logic [7:0]  io_axi_mem_awlen,
  input  logic [2:0]  io_axi_mem_awsize,
  input  logic [1:0]  io_axi_mem_awburst,
  input  logic        io_axi_mem_awlock,
  input  logic [3:0]  io_axi_mem_awcache,
  input  logic [2:0]  io_axi_mem_awprot,
  input  logic [3:0]  io_axi_mem_awregion,
  input  logic [3:0]  io_axi_mem_awuser,
  input  logic [3:0]  io_axi_mem_awqos,
  input  logic [5:0]  io_axi_mem_awatop,
  input  logic        io_axi_mem_awvalid,
  output logic        io_axi_mem_awready,

  input  logic [63:0] io_axi_mem_wdata,
  input  logic [7:0]  io_axi_mem_wstrb,
  input  logic        io_axi_mem_wlast,
  input  logic [3:0]  io_axi_mem_wuser,
  input  logic        io_axi_mem_wvalid,
  output logic        io_axi_mem_wready,

  output logic [3:0]  io_axi_mem_bid,
  output logic [1:0]  io_axi_mem_bresp,
  output logic [3:0]  io_axi_mem_buser,
  output logic        io_axi_mem_bvalid,
  input  logic        io_axi_mem_bready,

  input  logic [3:0]  io_axi_mem_arid,
  input  logic [63:0] io_axi_mem_araddr,
  input  logic [7:0]  io_axi_mem_arlen,
  input  logic [2:0]  io_axi_mem_arsize,
  input  logic [1:0]  io_axi_mem_arburst,
  input  logic        io_axi_mem_arlock,
  input  logic [3:0]  io_axi_mem_arcache,
  input  logic [2:0]  io_axi_mem_arprot,
  input  logic [3:0]  io_axi_mem_arregion,
  input  logic [3:0]  io_axi_mem_aruser,
  input  logic [3:0]  io_axi_mem_arqos,
  input  logic        io_axi_mem_arvalid,
  output logic        io_axi_mem_arready,

  output logic [3:0]  io_axi_mem_rid,
  output logic [63:0] io_axi_mem_rdata,
  output logic [1:0]  io_axi_mem_rresp,
  output logic        io_axi_mem_rlast,
  output logic [3:0]  io_axi_mem_ruser,
  output logic        io_axi_mem_rvalid,
  input  logic        io_axi_mem_rready
);

  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned SPAN_W = IDX_W + 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_WRESP = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  logic [1:0]  state_q;
  req_t        req_q;
  logic [7:0]  beat_q;
  logic        err_dec_q;
  logic        err_slv_q;
  logic        prio_wr_q;

  logic [63:0] mem [MEM_WORDS];

  logic [63:0]      next_addr;
  logic             wrap_ok;
  logic             in_range;
  logic             static_slv;
  logic             last_beat;
  logic             wlast_bad;
  logic             beat_dec;
  logic             beat_slv;
  logic             beat_err;
  logic             mem_we;
  logic [IDX_W-1:0] word_idx;
  logic             aw_hs;
  logic             ar_hs;

  axi_burst_addr_gen u_addr_gen (
    .addr      (req_q.addr),
    .len       (req_q.len),
    .size      (req_q.size),
    .burst     (req_q.burst),
    .next_addr (next_addr),
    .wrap_ok   (wrap_ok)
  );

  assign io_axi_mem_awready = (state_q == ST_IDLE) && io_axi_mem_awvalid &&
                              (!io_axi_mem_arvalid || prio_wr_q);
  assign io_axi_mem_arready = (state_q == ST_IDLE) && io_axi_mem_arvalid &&
                              (!io_axi_mem_awvalid || !prio_wr_q);
  assign aw_hs = io_axi_mem_awvalid && io_axi_mem_awready;
  assign ar_hs = io_axi_mem_arvalid && io_axi_mem_arready;

  // BASE_ADDR is window-aligned, so range membership is a compare of the upper bits.
  assign in_range   = (req_q.addr[63:SPAN_W] == BASE_ADDR[63:SPAN_W]);
  assign word_idx   = req_q.addr[SPAN_W-1:3];
  assign static_slv = !size_legal(req_q.size) || (req_q.burst == BURST_RSVD) ||
                      ((req_q.burst == BURST_WRAP) && !wrap_ok);
  assign last_beat  = (beat_q == req_q.len);
  assign wlast_bad  = (state_q == ST_WRITE) && (io_axi_mem_wlast != last_beat);
  assign beat_dec   = err_dec_q || !in_range;
  assign beat_slv   = err_slv_q || static_slv || wlast_bad;
  assign beat_err   = beat_dec || beat_slv;
  assign mem_we     = !rst_i && (state_q == ST_WRITE) && io_axi_mem_wvalid && !beat_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      beat_q    <= '0;
      err_dec_q <= 1'b0;
      err_slv_q <= 1'b0;
      prio_wr_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io_axi_mem_awvalid && io_axi_mem_arvalid) begin
            prio_wr_q <= !prio_wr_q;
          end
          if (aw_hs) begin
            req_q     <= '{id: io_axi_mem_awid, addr: io_axi_mem_awaddr, len: io_axi_mem_awlen,
                           size: io_axi_mem_awsize, burst: io_axi_mem_awburst};
            beat_q    <= '0;
            err_dec_q <= 1'b0;
            err_slv_q <= (io_axi_mem_awatop != 6'd0);
            state_q   <= ST_WRITE;
          end else if (ar_hs) begin
            req_q     <= '{id: io_axi_mem_arid, addr: io_axi_mem_araddr, len: io_axi_mem_arlen,
                           size: io_axi_mem_arsize, burst: io_axi_mem_arburst};
            beat_q    <= '0;
            err_dec_q <= 1'b0;
            err_slv_q <= 1'b0;
            state_q   <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (io_axi_mem_wvalid) begin
            err_dec_q  <= beat_dec;
            err_slv_q  <= beat_slv;
            req_q.addr <= next_addr;
            beat_q     <= beat_q + 8'd1;
            if (last_beat) begin
              state_q <= ST_WRESP;
            end
          end
        end
        ST_WRESP: begin
          if (io_axi_mem_bready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          if (io_axi_mem_rready) begin
            err_dec_q  <= beat_dec;
            err_slv_q  <= beat_slv;
            req_q.addr <= next_addr;
            beat_q     <= beat_q + 8'd1;
            if (last_beat) begin
              state_q <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (io_axi_mem_wstrb[b]) begin
          mem[word_idx][8*b +: 8] <= io_axi_mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign io_axi_mem_wready = (state_q == ST_WRITE);

  assign io_axi_mem_bvalid = (state_q == ST_WRESP);
  assign io_axi_mem_bid    = req_q.id;
  assign io_axi_mem_bresp  = (state_q == ST_WRESP) ? resp_merge(err_dec_q, err_slv_q) : RESP_OKAY;
  assign io_axi_mem_buser  = 4'd0;

  assign io_axi_mem_rvalid = (state_q == ST_READ);
  assign io_axi_mem_rid    = req_q.id;
  assign io_axi_mem_rdata  = ((state_q == ST_READ) && !beat_err) ? mem[word_idx] : 64'd0;
  assign io_axi_mem_rresp  = (state_q == ST_READ) ? resp_merge(beat_dec, beat_slv) : RESP_OKAY;
  assign io_axi_mem_rlast  = (state_q == ST_READ) && last_beat;
  assign io_axi_mem_ruser  = 4'd0;

  logic unused_sideband;
  assign unused_sideband = ^{io_axi_mem_awlock, io_axi_mem_awcache, io_axi_mem_awprot,
                             io_axi_mem_awregion, io_axi_mem_awuser, io_axi_mem_awqos,
                             io_axi_mem_wuser, io_axi_mem_arlock, io_axi_mem_arcache,
                             io_axi_mem_arprot, io_axi_mem_arregion, io_axi_mem_aruser,
                             io_axi_mem_arqos};

  // Atomics are answered with SLVERR, but a master issuing them is almost certainly misconfigured.
  a_no_atomics: assert property (@(posedge clk_i) disable iff (rst_i)
    (io_axi_mem_awvalid && io_axi_mem_awready) |-> (io_axi_mem_awatop == 6'd0));

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: bursts, wrap, strobes, decode errors, arbitration, stalls, reset.
module tb_axi_mem_responder;

  logic        clk;
  logic        rst;
  logic [3:0]  awid, arid, bid, rid;
  logic [63:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, arvalid, arready;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready, rlast, rvalid, rready;
  logic [3:0]  buser, ruser;

  int checks = 0;
  int errors = 0;
  logic [63:0] wd [16];
  logic [63:0] ex [16];

  axi_mem_responder dut (
    .clk_i(clk), .rst_i(rst),
    .io_axi_mem_awid(awid), .io_axi_mem_awaddr(awaddr), .io_axi_mem_awlen(awlen),
    .io_axi_mem_awsize(awsize), .io_axi_mem_awburst(awburst), .io_axi_mem_awlock(1'b0),
    .io_axi_mem_awcache(4'd0), .io_axi_mem_awprot(3'd0), .io_axi_mem_awregion(4'd0),
    .io_axi_mem_awuser(4'd0), .io_axi_mem_awqos(4'd0), .io_axi_mem_awatop(6'd0),
    .io_axi_mem_awvalid(awvalid), .io_axi_mem_awready(awready),
    .io_axi_mem_wdata(wdata), .io_axi_mem_wstrb(wstrb), .io_axi_mem_wlast(wlast),
    .io_axi_mem_wuser(4'd0), .io_axi_mem_wvalid(wvalid), .io_axi_mem_wready(wready),
    .io_axi_mem_bid(bid), .io_axi_mem_bresp(bresp), .io_axi_mem_buser(buser),
    .io_axi_mem_bvalid(bvalid), .io_axi_mem_bready(bready),
    .io_axi_mem_arid(arid), .io_axi_mem_araddr(araddr), .io_axi_mem_arlen(arlen),
    .io_axi_mem_arsize(arsize), .io_axi_mem_arburst(arburst), .io_axi_mem_arlock(1'b0),
    .io_axi_mem_arcache(4'd0), .io_axi_mem_arprot(3'd0), .io_axi_mem_arregion(4'd0),
    .io_axi_mem_aruser(4'd0), .io_axi_mem_arqos(4'd0),
    .io_axi_mem_arvalid(arvalid), .io_axi_mem_arready(arready),
    .io_axi_mem_rid(rid), .io_axi_mem_rdata(rdata), .io_axi_mem_rresp(rresp),
    .io_axi_mem_rlast(rlast), .io_axi_mem_ruser(ruser), .io_axi_mem_rvalid(rvalid),
    .io_axi_mem_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_aw(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                        input logic [1:0] burst);
    awid = id; awaddr = a; awlen = len; awsize = 3'd3; awburst = burst; awvalid = 1'b1;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                        input logic [1:0] burst);
    arid = id; araddr = a; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
  endtask

  task automatic wait_aw(input string tag);
    int n = 0;
    #1;
    while (!awready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_awready"}, {63'd0, awready}, 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic wait_ar(input string tag);
    int n = 0;
    #1;
    while (!arready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_arready"}, {63'd0, arready}, 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic w_burst(input string tag, input int n, input logic [7:0] strb);
    for (int i = 0; i < n; i++) begin
      wdata = wd[i]; wstrb = strb; wlast = (i == n - 1); wvalid = 1'b1;
      #1;
      chk({tag, "_wready"}, {63'd0, wready}, 64'd1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_check(input string tag, input logic [3:0] id, input logic [1:0] resp);
    #1;
    chk({tag, "_bvalid"}, {63'd0, bvalid}, 64'd1);
    chk({tag, "_bid"}, {60'd0, bid}, {60'd0, id});
    chk({tag, "_bresp"}, {62'd0, bresp}, {62'd0, resp});
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    #1;
    chk({tag, "_bvalid_drop"}, {63'd0, bvalid}, 64'd0);
  endtask

  task automatic r_burst(input string tag, input logic [3:0] id, input int n,
                         input logic [1:0] resp, input bit stall);
    int beat = 0;
    int cyc = 0;
    while (beat < n && cyc < 100) begin
      rready = stall ? cyc[0] : 1'b1;
      #1;
      chk({tag, "_rvalid"}, {63'd0, rvalid}, 64'd1);
      chk({tag, "_rid"}, {60'd0, rid}, {60'd0, id});
      chk({tag, "_rdata"}, rdata, ex[beat]);
      chk({tag, "_rresp"}, {62'd0, rresp}, {62'd0, resp});
      chk({tag, "_rlast"}, {63'd0, rlast}, {63'd0, (beat == n - 1)});
      if (rready && rvalid) beat++;
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    chk({tag, "_beats"}, 64'(beat), 64'(n));
    #1;
    chk({tag, "_rvalid_drop"}, {63'd0, rvalid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_awready", {63'd0, awready}, 64'd0);
    chk("rst_wready", {63'd0, wready}, 64'd0);
    chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_bid_bresp", {58'd0, bid, bresp}, 64'd0);
    chk("rst_rid_rresp_rlast", {57'd0, rid, rresp, rlast}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_user", {56'd0, buser, ruser}, 64'd0);

    // INCR write of four words, then read them back
    @(negedge clk);
    wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
    set_aw(4'd5, 64'h8000_0000, 8'd3, 2'b01);
    wait_aw("incr_w");
    w_burst("incr_w", 4, 8'hFF);
    b_check("incr_w", 4'd5, 2'b00);
    ex[0] = 64'h11; ex[1] = 64'h22; ex[2] = 64'h33; ex[3] = 64'h44;
    set_ar(4'd6, 64'h8000_0000, 8'd3, 2'b01);
    wait_ar("incr_r");
    r_burst("incr_r", 4'd6, 4, 2'b00, 1'b0);

    // WRAP read starting at the top of a 32-byte window
    ex[0] = 64'h44; ex[1] = 64'h11; ex[2] = 64'h22; ex[3] = 64'h33;
    set_ar(4'd7, 64'h8000_0018, 8'd3, 2'b10);
    wait_ar("wrap_r");
    r_burst("wrap_r", 4'd7, 4, 2'b00, 1'b0);

    // Partial strobe over an all-ones word
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    set_aw(4'd1, 64'h8000_0100, 8'd0, 2'b01);
    wait_aw("strb_w0");
    w_burst("strb_w0", 1, 8'hFF);
    b_check("strb_w0", 4'd1, 2'b00);
    wd[0] = 64'hAABB_CCDD_EEFF_0011;
    set_aw(4'd2, 64'h8000_0100, 8'd0, 2'b01);
    wait_aw("strb_w1");
    w_burst("strb_w1", 1, 8'h0F);
    b_check("strb_w1", 4'd2, 2'b00);
    ex[0] = 64'hFFFF_FFFF_EEFF_0011;
    set_ar(4'd3, 64'h8000_0100, 8'd0, 2'b01);
    wait_ar("strb_r");
    r_burst("strb_r", 4'd3, 1, 2'b00, 1'b0);

    // Out-of-range write must not land on the word whose low address bits match
    wd[0] = 64'h5555_AAAA_5555_AAAA;
    set_aw(4'd4, 64'h8000_1000, 8'd0, 2'b01);
    wait_aw("alias_w");
    w_burst("alias_w", 1, 8'hFF);
    b_check("alias_w", 4'd4, 2'b00);
    wd[0] = 64'h1234;
    set_aw(4'd9, 64'h0000_1000, 8'd0, 2'b01);
    wait_aw("oor_w");
    w_burst("oor_w", 1, 8'hFF);
    b_check("oor_w", 4'd9, 2'b11);
    ex[0] = 64'h5555_AAAA_5555_AAAA;
    set_ar(4'd4, 64'h8000_1000, 8'd0, 2'b01);
    wait_ar("alias_r");
    r_burst("alias_r", 4'd4, 1, 2'b00, 1'b0);
    ex[0] = 64'd0; ex[1] = 64'd0;
    set_ar(4'd10, 64'h0000_1000, 8'd1, 2'b01);
    wait_ar("oor_r");
    r_burst("oor_r", 4'd10, 2, 2'b11, 1'b0);

    // Simultaneous AW and AR: write wins first, then read wins
    wd[0] = 64'hC0DE_0001;
    set_aw(4'd11, 64'h8000_0180, 8'd0, 2'b01);
    set_ar(4'd12, 64'h8000_0000, 8'd0, 2'b01);
    #1;
    chk("arb1_arready_blocked", {63'd0, arready}, 64'd0);
    wait_aw("arb1");
    w_burst("arb1", 1, 8'hFF);
    b_check("arb1", 4'd11, 2'b00);
    ex[0] = 64'h11;
    wait_ar("arb1");
    r_burst("arb1", 4'd12, 1, 2'b00, 1'b0);
    @(negedge clk);
    wd[0] = 64'hC0DE_0002;
    set_aw(4'd13, 64'h8000_0180, 8'd0, 2'b01);
    set_ar(4'd14, 64'h8000_0180, 8'd0, 2'b01);
    #1;
    chk("arb2_awready_blocked", {63'd0, awready}, 64'd0);
    ex[0] = 64'hC0DE_0001;
    wait_ar("arb2");
    r_burst("arb2", 4'd14, 1, 2'b00, 1'b0);
    wait_aw("arb2");
    w_burst("arb2", 1, 8'hFF);
    b_check("arb2", 4'd13, 2'b00);

    // Eight-beat read with rready toggling every cycle
    for (int i = 0; i < 8; i++) begin
      wd[i] = 64'h100 + 64'(i);
      ex[i] = 64'h100 + 64'(i);
    end
    set_aw(4'd8, 64'h8000_0200, 8'd7, 2'b01);
    wait_aw("bp_w");
    w_burst("bp_w", 8, 8'hFF);
    b_check("bp_w", 4'd8, 2'b00);
    set_ar(4'd15, 64'h8000_0200, 8'd7, 2'b01);
    wait_ar("bp_r");
    r_burst("bp_r", 4'd15, 8, 2'b00, 1'b1);

    // Reset in the middle of a read burst
    set_ar(4'd2, 64'h8000_0200, 8'd7, 2'b01);
    wait_ar("rst_r");
    rready = 1'b1;
    #1;
    chk("rst_r_beat0", rdata, 64'h100);
    @(negedge clk);
    #1;
    chk("rst_r_beat1", rdata, 64'h101);
    rst = 1'b1;
    rready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_r_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_r_rdata", rdata, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    ex[0] = 64'h105;
    set_ar(4'd3, 64'h8000_0228, 8'd0, 2'b01);
    wait_ar("post_rst");
    r_burst("post_rst", 4'd3, 1, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 slave memory model sitting at the far end of the core's `io_axi_mem_*` master port. It accepts the core's read and write bursts and serves them from an internal word-addressed array, returning B and R responses with the request ID echoed. It is used as the boot/main memory in simulation and FPGA bring-up tops, and handles one transaction at a time.

## Interface
Parameters:
- `MEM_WORDS`, default 1024: number of 64-bit words; must be a power of two.
- `BASE_ADDR`, default 64'h8000_0000: byte address of word 0; must be aligned to `MEM_WORDS*8`.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- AW channel, all inputs except `io_axi_mem_awready` (out 1):
  - `io_axi_mem_awid` in 4; `awaddr` in 64; `awlen` in 8; `awsize` in 3; `awburst` in 2.
  - `awlock` in 1; `awcache` in 4; `awprot` in 3; `awregion` in 4; `awuser` in 4; `awqos` in 4; `awatop` in 6; `awvalid` in 1.
- W channel: `io_axi_mem_wdata` in 64; `wstrb` in 8; `wlast` in 1; `wuser` in 4; `wvalid` in 1; `wready` out 1.
- B channel: `io_axi_mem_bid` out 4; `bresp` out 2; `buser` out 4; `bvalid` out 1; `bready` in 1.
- AR channel: mirrors AW without `atop` (`arid` … `arvalid`) as inputs; `arready` out 1.
- R channel: `io_axi_mem_rid` out 4; `rdata` out 64; `rresp` out 2; `rlast` out 1; `ruser` out 4; `rvalid` out 1; `rready` in 1.
- lock, cache, prot, region, qos and user inputs are accepted and ignored.

## Operation
- FSM states: IDLE, WRITE, WRESP, READ.
- IDLE:
  - `awready` = `awvalid` AND (NOT `arvalid` OR `prio_wr`).
  - `arready` = `arvalid` AND (NOT `awvalid` OR NOT `prio_wr`).
  - `prio_wr` toggles after every grant taken while both valids were high (round-robin). It resets to 1.
- Handshake latch: on an AW or AR handshake, latch id, addr, len, size and burst. Clear the beat counter and the error flag.
- Error flag is set when:
  - `size` > 3: SLVERR;
  - the address falls outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*8): DECERR; checked per beat;
  - `awatop` != 0: SLVERR. Atomics are unsupported; an SVA assertion flags them.
- Once set, the error flag is sticky for the burst.
- WRITE:
  - `wready`=1.
  - Each beat with no error writes the bytes selected by `wstrb` into word `(addr-BASE_ADDR)>>3`.
  - The final beat is beat count == len. `wlast` is ignored for termination; a `wlast` mismatch sets SLVERR.
  - After the final beat, go to WRESP.
- WRESP:
  - `bvalid`=1, `bid`=latched id, `bresp`=OKAY/SLVERR/DECERR with DECERR taking precedence.
  - Return to IDLE on `bready`.
- READ:
  - `rvalid`=1, `rid`=latched id.
  - `rdata` = mem[current word], or 0 if the beat is erroneous; `rresp` is per beat.
  - `rlast` = (beat count == len).
  - Advance on `rready`; return to IDLE after the last beat.
- Address advance per beat:
  - FIXED: unchanged.
  - INCR: addr + (1<<size).
  - WRAP: wrap within the (len+1)<<size aligned window. len must be 1, 3, 7 or 15; otherwise SLVERR.
  - Reserved burst 2'b11: SLVERR.
- `buser` and `ruser` are always 0. Reads always return the full 64-bit word (narrow-lane selection is the master's job).

## Timing
- Reset values: all ready/valid outputs 0; `bid`, `bresp`, `rid`, `rresp`, `rlast` and `rdata` 0; state IDLE; `prio_wr`=1. Memory contents are not reset.
- Reset asserted mid-burst aborts the burst immediately. Partial writes already done remain in memory.
- AW handshake in cycle N: `wready` high from N+1. A beat is accepted every cycle `wvalid` is high.
- Last W beat in cycle M: `bvalid` in M+1, held until `bready`.
- AR handshake in N: first `rvalid` in N+1. Back-to-back beats run at 1/cycle while `rready`=1.
- `rdata` is read combinationally from the registered beat address. Outputs are stable while valid is high and ready is low.
- Returning to IDLE costs one cycle, so the next AW/AR can be accepted no earlier than the cycle after B/last-R completes.
- `awready`/`arready` depend combinationally on the valids. The valids do not depend on readies.

## Structure
- Resp codes, burst encodings and len/size types come from the shared `axi_pkg`. Error-priority helper functions go in the same package.
- Sub-module `axi_burst_addr_gen` is purely combinational: (addr, len, size, burst) → next addr, plus wrap-legality flag.
- Memory is an array inside the top module, byte-enable write. It must be inferable as distributed/LUT RAM.

## Test plan
- INCR write: len=3, size=3, addr 0x8000_0000, data 0x11..0x44, strb 0xFF → bresp OKAY, bid echoed. Then an INCR read returns the same 4 words with rlast on beat 3.
- WRAP read: addr 0x8000_0018, len=3, size=3 → words at offsets 0x18, 0x00, 0x08, 0x10.
- Partial strobe: write 0xAABB… with strb 0x0F over 0xFFFF_FFFF_FFFF_FFFF → read 0xFFFF_FFFF_xxxx_xxxx with the low half updated.
- Out-of-range: write to 0x0000_1000 → bresp DECERR, memory unchanged. Read there → rdata 0, rresp DECERR on every beat.
- Simultaneous AW and AR in the same cycle, twice → write granted first, read second, then the order alternates.
- R backpressure: `rready` toggled every other cycle during len=7 → no beat lost or duplicated, `rdata` stable while stalled. Then `rst_i` asserted mid-burst → `rvalid` 0 the next cycle.
